pattern_seq_ctrl: RTL and testbench

- Frame-based serial sequence controller. It shifts a serial bit stream through a 4-bit window and counts occurrences of a 4-bit pattern (default 0111, i.e. ~a&b&c&d with a = oldest bit).
- It sequences one frame of FRAME_LEN bits per start/done handshake and reports a match pulse plus a saturating match count.
- It sits between a serial source and downstream control logic that consumes the count.

---
 rtl/pattern_seq_ctrl_pkg.sv | 16 +
 rtl/pattern_seq_ctrl_cmp4.sv | 16 +
 rtl/pattern_seq_ctrl.sv | 124 ++++++++++++
 tb/tb_pattern_seq_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/pattern_seq_ctrl_pkg.sv
// Shared types and constants for the serial pattern sequence controller.
// No logic lives here.
// No flow control of its own.
package pattern_seq_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [3:0] PAT_0111  = 4'b0111;
    localparam logic [2:0] FILL_FULL = 3'd4;
    localparam logic [2:0] FILL_CMP  = 3'd3;

endpackage

// File: rtl/pattern_seq_ctrl_cmp4.sv
// Exact 4-bit equality against a fixed pattern; a is the oldest bit.
// Purely combinational, zero latency.
// No backpressure.
module pattern_cmp4 #(
    parameter logic [3:0] PATTERN = 4'b0111
) (
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d,
    output logic o
);

    assign o = ({a, b, c, d} == PATTERN);

endmodule

// File: rtl/pattern_seq_ctrl.sv
// Frame sequencer: shifts FRAME_LEN serial bits, pulses and counts pattern matches.
// match_pulse one cycle after the matching bit; done one cycle after the last bit.
// Source is paced by bit_valid only; gaps of any length hold all state.
module pattern_seq_ctrl
    import pattern_seq_ctrl_pkg::*;
#(
    parameter int         FRAME_LEN = 16,
    parameter int         CNT_W     = 5,
    parameter logic [3:0] PATTERN   = PAT_0111
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             cfg_overlap,
    input  logic             bit_in,
    input  logic             bit_valid,
    output logic             busy,
    output logic             match_pulse,
    output logic [CNT_W-1:0] match_cnt,
    output logic             done
);

    localparam logic [7:0]       LAST_IDX = 8'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t             state_q, state_d;
    // Only the three older bits are stored; the newest bit of the window is bit_in itself.
    logic [2:0]         window_q;
    logic [2:0]         fill_q, fill_d;
    logic [7:0]         bit_idx_q;
    logic               overlap_q;
    logic [CNT_W-1:0]   match_cnt_q;
    logic               match_pulse_q;

    logic               frame_start;
    logic               shift_en;
    logic               last_bit;
    logic               cmp_hit;
    logic               match_hit;

    assign frame_start = (state_q == ST_IDLE) && start;
    assign shift_en    = (state_q == ST_SHIFT) && bit_valid;
    assign last_bit    = shift_en && (bit_idx_q == LAST_IDX);
    assign match_hit   = shift_en && (fill_q >= FILL_CMP) && cmp_hit;

    pattern_cmp4 #(
        .PATTERN (PATTERN)
    ) u_cmp (
        .a (window_q[2]),
        .b (window_q[1]),
        .c (window_q[0]),
        .d (bit_in),
        .o (cmp_hit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_SHIFT;
            ST_SHIFT: if (last_bit) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            ST_SHIFT: busy = 1'b1;
            ST_DONE:  done = 1'b1;
            default:  ;
        endcase
    end

    // Non-overlap restarts the fill so the next match needs four fresh bits.
    always_comb begin
        fill_d = fill_q;
        if (match_hit && !overlap_q) begin
            fill_d = 3'd0;
        end else if (fill_q != FILL_FULL) begin
            fill_d = fill_q + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            window_q      <= 3'd0;
            fill_q        <= 3'd0;
            bit_idx_q     <= 8'd0;
            overlap_q     <= 1'b0;
            match_cnt_q   <= '0;
            match_pulse_q <= 1'b0;
        end else begin
            match_pulse_q <= match_hit;
            if (frame_start) begin
                window_q    <= 3'd0;
                fill_q      <= 3'd0;
                bit_idx_q   <= 8'd0;
                match_cnt_q <= '0;
                overlap_q   <= cfg_overlap;
            end else if (shift_en) begin
                window_q  <= {window_q[1:0], bit_in};
                fill_q    <= fill_d;
                bit_idx_q <= bit_idx_q + 8'd1;
                if (match_hit && (match_cnt_q != CNT_MAX)) begin
                    match_cnt_q <= match_cnt_q + CNT_W'(1);
                end
            end
        end
    end

    assign match_pulse = match_pulse_q;
    assign match_cnt   = match_cnt_q;

endmodule

// File: tb/tb_pattern_seq_ctrl.sv
// Three controller instances (default, all-ones pattern, 2-bit counter) share one stimulus
// and are checked every cycle against a bit-history model of the matching rules.
module tb_pattern_seq_ctrl;

    localparam int FRAME_LEN = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       cfg_overlap;
    logic       bit_in;
    logic       bit_valid;

    logic [2:0] busy_w;
    logic [2:0] pulse_w;
    logic [2:0] done_w;
    logic [4:0] cnt0;
    logic [4:0] cnt1;
    logic [1:0] cnt2;

    int vectors    = 0;
    int miscompares = 0;

    // Reference model state
    int         phase;          // 0 idle, 1 accepting bits, 2 frame-end cycle
    bit         hist[$];
    bit         ovl;
    int         exp_cnt[3];
    int         last_end[3];
    bit         exp_pulse[3];
    bit [3:0]   ref_pat[3] = '{4'b0111, 4'b1111, 4'b0111};
    int         cnt_max[3] = '{31, 31, 3};

    always #5 clk = ~clk;

    pattern_seq_ctrl u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg_overlap(cfg_overlap),
        .bit_in(bit_in), .bit_valid(bit_valid), .busy(busy_w[0]),
        .match_pulse(pulse_w[0]), .match_cnt(cnt0), .done(done_w[0])
    );

    pattern_seq_ctrl #(.PATTERN(4'b1111)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg_overlap(cfg_overlap),
        .bit_in(bit_in), .bit_valid(bit_valid), .busy(busy_w[1]),
        .match_pulse(pulse_w[1]), .match_cnt(cnt1), .done(done_w[1])
    );

    pattern_seq_ctrl #(.CNT_W(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg_overlap(cfg_overlap),
        .bit_in(bit_in), .bit_valid(bit_valid), .busy(busy_w[2]),
        .match_pulse(pulse_w[2]), .match_cnt(cnt2), .done(done_w[2])
    );

    function automatic logic [31:0] cnt_of(input int k);
        case (k)
            0:       return 32'(cnt0);
            1:       return 32'(cnt1);
            default: return 32'(cnt2);
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        phase = 0;
        hist.delete();
        ovl = 1'b0;
        for (int k = 0; k < 3; k++) begin
            exp_cnt[k]   = 0;
            last_end[k]  = -1;
            exp_pulse[k] = 1'b0;
        end
    endtask

    // One clock edge of the spec's rules, expressed on the history of accepted bits.
    task automatic model_step(input logic s, input logic bv, input logic bi, input logic ov);
        int n;
        bit [3:0] win;
        for (int k = 0; k < 3; k++) exp_pulse[k] = 1'b0;
        case (phase)
            0: if (s) begin
                phase = 1;
                hist.delete();
                ovl = ov;
                for (int k = 0; k < 3; k++) begin
                    exp_cnt[k]  = 0;
                    last_end[k] = -1;
                end
            end
            1: if (bv) begin
                hist.push_back(bi);
                n = hist.size();
                if (n >= 4) begin
                    win = {hist[n-4], hist[n-3], hist[n-2], hist[n-1]};
                    for (int k = 0; k < 3; k++) begin
                        if (win == ref_pat[k] && (ovl || (n - 4) > last_end[k])) begin
                            exp_pulse[k] = 1'b1;
                            last_end[k]  = n - 1;
                            if (exp_cnt[k] < cnt_max[k]) exp_cnt[k]++;
                        end
                    end
                end
                if (n == FRAME_LEN) phase = 2;
            end
            default: phase = 0;
        endcase
    endtask

    task automatic check_all();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("busy%0d", k),  32'(busy_w[k]),  32'(phase == 1));
            chk($sformatf("done%0d", k),  32'(done_w[k]),  32'(phase == 2));
            chk($sformatf("pulse%0d", k), 32'(pulse_w[k]), 32'(exp_pulse[k]));
            chk($sformatf("cnt%0d", k),   cnt_of(k),       32'(exp_cnt[k]));
        end
    endtask

    // Called at a falling edge; returns at the next falling edge after checking.
    task automatic cycle(input logic s, input logic bv, input logic bi);
        logic ov;
        start = s;
        bit_valid = bv;
        bit_in = bi;
        ov = cfg_overlap;
        @(posedge clk);
        model_step(s, bv, bi, ov);
        @(negedge clk);
        check_all();
    endtask

    task automatic run_frame(input logic [15:0] fb, input logic ov, input int gap_max,
                             input int stray_at);
        logic [15:0] bits;
        bits = fb;
        cfg_overlap = ov;
        cycle(1'b1, 1'b0, 1'b0);
        cfg_overlap = ~ov;
        for (int i = 0; i < FRAME_LEN; i++) begin
            repeat ($urandom_range(0, gap_max)) cycle(1'($urandom), 1'b0, 1'($urandom));
            cycle(1'(i == stray_at), 1'b1, bits[15-i]);
        end
        chk("frame_end_done", 32'(done_w[0]), 32'd1);
        chk("frame_end_busy", 32'(busy_w[0]), 32'd0);
        cycle(1'b0, 1'b0, 1'b0);
        chk("idle_after_done", 32'(done_w[0] | busy_w[0]), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        cfg_overlap = 1'b0;
        bit_in = 1'b0;
        bit_valid = 1'b0;
        model_reset();
        @(negedge clk);
        check_all();
        rst_n = 1'b1;
        cycle(1'b0, 1'b0, 1'b0);

        // Two matches with a continuous source
        run_frame(16'b0111_0111_0000_0000, 1'b0, 0, -1);
        chk("tp1_cnt0", 32'(cnt0), 32'd2);
        chk("tp1_cnt1", 32'(cnt1), 32'd0);

        // Six ones then zeros, overlap on and off
        run_frame(16'b1111_1100_0000_0000, 1'b1, 0, -1);
        chk("ones_ovl_cnt1", 32'(cnt1), 32'd3);
        run_frame(16'b1111_1100_0000_0000, 1'b0, 0, -1);
        chk("ones_novl_cnt1", 32'(cnt1), 32'd1);

        // Counter saturation on the 2-bit instance
        run_frame(16'b0111_0111_0111_0111, 1'b0, 0, -1);
        chk("sat_cnt2", 32'(cnt2), 32'd3);
        chk("sat_cnt0", 32'(cnt0), 32'd4);

        // Idle bit_valid is ignored; gapped frame with a match only on the last bit
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'($urandom));
        chk("idle_hold_cnt0", 32'(cnt0), 32'd4);
        run_frame(16'b0000_0000_0000_0111, 1'b0, 3, -1);
        chk("gap_cnt0", 32'(cnt0), 32'd1);

        // Start while busy must not restart the frame
        run_frame(16'b0111_0000_0000_0111, 1'b1, 1, 4);
        chk("stray_start_cnt0", 32'(cnt0), 32'd2);

        // Asynchronous reset mid-frame
        cfg_overlap = 1'b0;
        cycle(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) cycle(1'b0, 1'b1, 1'(i >= 1 && i <= 3));
        chk("pre_reset_cnt0", 32'(cnt0), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst_busy",  32'(busy_w[0]),  32'd0);
        chk("arst_done",  32'(done_w[0]),  32'd0);
        chk("arst_pulse", 32'(pulse_w[0]), 32'd0);
        chk("arst_cnt",   32'(cnt0),       32'd0);
        @(negedge clk);
        check_all();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0);
        run_frame(16'b0111_0000_0000_0000, 1'b0, 0, -1);
        chk("post_reset_cnt0", 32'(cnt0), 32'd1);

        // Random frames, gaps and overlap settings
        for (int f = 0; f < 24; f++) begin
            run_frame(16'($urandom), 1'($urandom), 2, int'($urandom_range(0, 20)));
            repeat ($urandom_range(0, 2)) cycle(1'b0, 1'($urandom), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
